// File: rtl/survivor_traceback_reader.sv
// Viterbi traceback reader: walks packed survivor words backwards from a start address and
// state, unpacking two stages per RAM word and emitting decoded bits after the merge depth.
module survivor_traceback_reader #(
  parameter int unsigned N_ACS       = 4,
  parameter int unsigned WD_RAM_DATA = 8,
  parameter int unsigned WD_STATE    = 2,
  parameter int unsigned WD_ADDR     = 6,
  parameter int unsigned TB_DEPTH    = 2,
  parameter int unsigned DEC_LEN     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WD_ADDR-1:0]     start_addr_i,
  input  logic [WD_STATE-1:0]    start_state_i,
  output logic                   ram_rd_o,
  output logic [WD_ADDR-1:0]     ram_addr_o,
  input  logic [WD_RAM_DATA-1:0] ram_data_i,
  output logic                   busy_o,
  output logic                   dec_valid_o,
  output logic                   dec_bit_o,
  output logic                   done_o
);

  localparam int unsigned NumStages = TB_DEPTH + DEC_LEN;
  localparam int unsigned NumWords  = NumStages / 2;
  localparam int unsigned CntW      = $clog2(NumStages + 1);

  typedef enum logic [2:0] {StIdle, StRd, StHi, StLo, StFin} state_e;

  state_e              fsm_q, fsm_d;
  logic [WD_ADDR-1:0]  addr_q, addr_d;
  logic [WD_STATE-1:0] trel_q, trel_d;
  logic [CntW-1:0]     word_q, word_d;
  logic [CntW-1:0]     stage_q, stage_d;
  logic [N_ACS-1:0]    lo_q, lo_d;

  logic [N_ACS-1:0]    half;
  logic                surv_bit;
  logic                last_word;
  logic                emit;

  // HI consumes the newer stage straight off the RAM bus; LO uses the half latched in HI.
  assign half      = (fsm_q == StHi) ? ram_data_i[WD_RAM_DATA-1:N_ACS] : lo_q;
  assign surv_bit  = half[trel_q];
  assign last_word = (word_q == CntW'(NumWords - 1));
  assign emit      = (stage_q >= CntW'(TB_DEPTH));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= StIdle;
      addr_q  <= '0;
      trel_q  <= '0;
      word_q  <= '0;
      stage_q <= '0;
      lo_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      addr_q  <= addr_d;
      trel_q  <= trel_d;
      word_q  <= word_d;
      stage_q <= stage_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (start_i) fsm_d = StRd;
      StRd:    fsm_d = StHi;
      StHi:    fsm_d = StLo;
      StLo:    fsm_d = last_word ? StFin : StRd;
      StFin:   fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    trel_d  = trel_q;
    word_d  = word_q;
    stage_d = stage_q;
    lo_d    = lo_q;
    unique case (fsm_q)
      StIdle: begin
        if (start_i) begin
          addr_d  = start_addr_i;
          trel_d  = start_state_i;
          word_d  = '0;
          stage_d = '0;
        end
      end
      StHi: begin
        lo_d    = ram_data_i[N_ACS-1:0];
        trel_d  = {trel_q[WD_STATE-2:0], surv_bit};
        stage_d = stage_q + CntW'(1);
      end
      StLo: begin
        trel_d  = {trel_q[WD_STATE-2:0], surv_bit};
        stage_d = stage_q + CntW'(1);
        word_d  = word_q + CntW'(1);
        addr_d  = addr_q - WD_ADDR'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_rd_o    = 1'b0;
    ram_addr_o  = '0;
    busy_o      = (fsm_q != StIdle);
    done_o      = 1'b0;
    dec_valid_o = 1'b0;
    dec_bit_o   = 1'b0;
    unique case (fsm_q)
      StRd: begin
        ram_rd_o   = 1'b1;
        ram_addr_o = addr_q;
      end
      StHi, StLo: begin
        dec_valid_o = emit;
        dec_bit_o   = emit & trel_q[WD_STATE-1];
      end
      StFin:   done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_survivor_traceback_reader.sv
// Directed, table-driven bench for survivor_traceback_reader with a behavioural survivor RAM.
module tb_survivor_traceback_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] start_addr;
  logic [1:0] start_state;
  logic       ram_rd;
  logic [5:0] ram_addr;
  logic [7:0] ram_data;
  logic       busy;
  logic       dec_valid;
  logic       dec_bit;
  logic       done;

  logic [7:0] mem [64];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] addr;
    logic [1:0] st;
    logic [7:0] w0;
    logic [7:0] w1;
    logic       b0;
    logic       b1;
  } vec_t;

  vec_t vecs [5];

  survivor_traceback_reader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .start_addr_i (start_addr),
    .start_state_i(start_state),
    .ram_rd_o     (ram_rd),
    .ram_addr_o   (ram_addr),
    .ram_data_i   (ram_data),
    .busy_o       (busy),
    .dec_valid_o  (dec_valid),
    .dec_bit_o    (dec_bit),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency.
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one traceback; optionally pulses Start again during HI of the first word.
  task automatic run_vec(input int idx, input bit poke);
    vec_t        v;
    logic [5:0]  a1;
    logic [10:0] exp;
    v  = vecs[idx];
    a1 = v.addr - 6'd1;
    mem[v.addr] = v.w0;
    mem[a1]     = v.w1;
    start       = 1'b1;
    start_addr  = v.addr;
    start_state = v.st;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      // {rd, addr, dv, db, done, busy}
      exp = {1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      if (c == 1) exp = {1'b1, v.addr, 1'b0, 1'b0, 1'b0, 1'b1};
      if (c == 4) exp = {1'b1, a1, 1'b0, 1'b0, 1'b0, 1'b1};
      if (c == 5) exp = {1'b0, 6'd0, 1'b1, v.b0, 1'b0, 1'b1};
      if (c == 6) exp = {1'b0, 6'd0, 1'b1, v.b1, 1'b0, 1'b1};
      if (c == 7) exp = {1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      check($sformatf("vec%0d cyc%0d", idx, c),
            {ram_rd, ram_addr, dec_valid, dec_bit, done, busy}, exp);
      if (poke && c == 2) begin
        start       = 1'b1;
        start_addr  = 6'd40;
        start_state = 2'b11;
      end
      if (poke && c == 3) start = 1'b0;
    end
    @(negedge clk);
    check($sformatf("vec%0d idle", idx), {ram_rd, ram_addr, dec_valid, dec_bit, done, busy},
          11'd0);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{addr: 6'd5,  st: 2'b00, w0: 8'h10, w1: 8'h00, b0: 1'b1, b1: 1'b0};
    vecs[1] = '{addr: 6'd5,  st: 2'b00, w0: 8'hFF, w1: 8'hFF, b0: 1'b1, b1: 1'b1};
    vecs[2] = '{addr: 6'd0,  st: 2'b00, w0: 8'h10, w1: 8'h00, b0: 1'b1, b1: 1'b0};
    vecs[3] = '{addr: 6'd33, st: 2'b10, w0: 8'hB1, w1: 8'h5A, b0: 1'b0, b1: 1'b1};
    vecs[4] = '{addr: 6'd63, st: 2'b01, w0: 8'hDB, w1: 8'h3C, b0: 1'b0, b1: 1'b0};
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    ram_data    = 8'h00;
    start       = 1'b0;
    start_addr  = 6'd0;
    start_state = 2'b00;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {ram_rd, ram_addr, dec_valid, dec_bit, done, busy}, 11'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, issued back-to-back (Start in the idle cycle right after Done).
    for (int i = 0; i < 5; i++) run_vec(i, 1'b0);

    // Busy lockout: a second Start during HI must be ignored.
    @(negedge clk);
    run_vec(0, 1'b1);

    // Reset during LO of the first word aborts with no Done.
    @(negedge clk);
    mem[5] = 8'h10;
    mem[4] = 8'h00;
    start       = 1'b1;
    start_addr  = 6'd5;
    start_state = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset mid-op", {ram_rd, ram_addr, dec_valid, dec_bit, done, busy}, 11'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy || ram_rd) done_seen++;
    end
    check("post-abort quiet", 11'(done_seen), 11'd0);

    // Fresh start after abort reproduces the basic case.
    run_vec(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
